// File: rtl/spi_slave.sv
// Mode-0 SPI slave, LSB first, with single-byte transmit and receive buffers.
// Define SPI_SLAVE_OVERRUN_EN to drop bytes that arrive while rx_data is unacknowledged and flag overrun.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic       overrun,
`endif
    output logic       busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic [BYTE_W-1:0] r_tx_buf;
    logic              r_tx_ready;
    logic [BYTE_W-1:0] r_tx_shift;
    logic [BYTE_W-2:0] r_rx_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [BYTE_W-1:0] r_rx_data;
    logic              r_rx_valid;

    logic              w_sclk_s;
    logic              w_cs_s;
    logic              w_mosi_s;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_enter;
    logic              w_exit;
    logic              w_shift_rise;
    logic              w_shift_fall;
    logic              w_done;
    logic              w_consume;
    logic [BYTE_W-1:0] w_tx_src;
    logic [BYTE_W-1:0] w_rx_next;

    // Input synchronizers plus one delay flop each for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_enter      = 1'b0;
        w_exit       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = SHIFT;
                    w_enter      = 1'b1;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_state_next = IDLE;
                    w_exit       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_shift_rise = (r_state == SHIFT) && w_sclk_rise;
    assign w_shift_fall = (r_state == SHIFT) && w_sclk_fall;
    assign w_done       = w_shift_rise && (r_bit_cnt == CNT_W'(BYTE_W - 1));
    assign w_consume    = w_enter || w_done;
    assign w_tx_src     = r_tx_ready ? '0 : r_tx_buf;
    assign w_rx_next    = {w_mosi_s, r_rx_shift};

    // Transmit side: buffer handshake and shifter; miso is the shifter LSB, zero while idle.
    // The falling edge right after a byte wrap must not shift, or the reloaded bit 0 would be lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_buf   <= '0;
            r_tx_ready <= 1'b1;
            r_tx_shift <= '0;
        end else begin
            if (w_consume) begin
                r_tx_ready <= 1'b1;
            end else if (tx_load && r_tx_ready) begin
                r_tx_buf   <= tx_data;
                r_tx_ready <= 1'b0;
            end

            if (w_exit) begin
                r_tx_shift <= '0;
            end else if (w_consume) begin
                r_tx_shift <= w_tx_src;
            end else if (w_shift_fall && (r_bit_cnt != '0)) begin
                r_tx_shift <= {1'b0, r_tx_shift[BYTE_W-1:1]};
            end
        end
    end

    // Receive side: shifter, bit counter and the output byte register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_shift <= '0;
            r_bit_cnt  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_enter) begin
                r_bit_cnt <= '0;
            end else if (w_shift_rise) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            if (w_shift_rise) begin
                r_rx_shift <= w_rx_next[BYTE_W-1:1];
            end

`ifdef SPI_SLAVE_OVERRUN_EN
            if (w_done && !(r_rx_valid && !rx_ack)) begin
`else
            if (w_done) begin
`endif
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
            end else if (rx_ack) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun <= 1'b0;
        end else if (w_done && r_rx_valid && !rx_ack) begin
            r_overrun <= 1'b1;
        end else if (rx_ack) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;
`endif

    assign miso     = r_tx_shift[0];
    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state == SHIFT);

endmodule
